// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//
// Shared definitions for the instruction fetch stage:
//   PC_W             - width of the program counter / instruction byte address
//   INSTR_W          - width of an instruction word
//   RESET_PC_DEFAULT - default PC loaded when the stage is reset
//   fetch_state_t    - fetch controller states
//   is_word_aligned  - true when a byte address lands on a 32-bit boundary
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 12'h000;

    // S_FETCH : request outstanding, waiting for memory to answer
    // S_VALID : instruction held, waiting for the consumer to retire it
    // S_FAULT : a misaligned redirect was seen; only reset leaves this state
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

    // Instructions are 32-bit words, so the two low address bits must be zero.
    function automatic logic is_word_aligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Single-entry instruction fetch stage. Issues a read to instruction memory
// at pc, captures the returned word, and holds it until the consumer retires
// it (advance) or the pipeline is redirected (flush). A PC load to an address
// that is not word-aligned parks the stage in a sticky fault state that only
// reset can clear.
//
// Parameters
//   RESET_PC     - PC value loaded on reset
//
// Ports
//   CLK          in   1   clock, all state changes on the rising edge
//   RSTn         in   1   asynchronous active-low reset
//   nextPc       in   12  next PC chosen by the PC mux
//   advance      in   1   consumer retired the held instruction; load nextPc
//   flush        in   1   redirect; abort any outstanding fetch, load nextPc
//   I_MEM_REQ    out  1   instruction-memory read request
//   I_MEM_ADDR   out  12  instruction-memory byte address (always pc)
//   I_MEM_READY  in   1   I_MEM_DI is valid for the current request
//   I_MEM_DI     in   32  instruction word from memory
//   pc           out  12  address of the instruction being fetched or held
//   pcInc4       out  32  zero-extended pc + 4 (wraps at 12 bits)
//   instr        out  32  held instruction word
//   instrValid   out  1   instr is valid for pc
//   fault        out  1   sticky misaligned-target indication
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [PC_W-1:0]     nextPc,
    input  logic                advance,
    input  logic                flush,
    output logic                I_MEM_REQ,
    output logic [PC_W-1:0]     I_MEM_ADDR,
    input  logic                I_MEM_READY,
    input  logic [INSTR_W-1:0]  I_MEM_DI,
    output logic [PC_W-1:0]     pc,
    output logic [INSTR_W-1:0]  pcInc4,
    output logic [INSTR_W-1:0]  instr,
    output logic                instrValid,
    output logic                fault
);

    fetch_state_t    state;
    logic            target_aligned;
    logic [PC_W-1:0] pc_plus4;

    assign target_aligned = is_word_aligned(nextPc);

    // The request and address are pure decodes of registered state, so they
    // are glitch-free and change only on a clock edge or on reset.
    assign I_MEM_REQ  = (state == S_FETCH);
    assign I_MEM_ADDR = pc;

    // pc + 4 deliberately wraps inside the 12-bit address space before being
    // zero-extended, so 12'hFFC feeds back as 32'h0.
    assign pc_plus4 = pc + PC_W'(4);
    assign pcInc4   = {{(INSTR_W - PC_W){1'b0}}, pc_plus4};

    // Fetch controller. flush is checked first in every live state so that a
    // redirect always wins over advance and over data returning in the same
    // cycle. Any PC load that targets a misaligned address leaves pc alone and
    // freezes the stage in S_FAULT.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            instr      <= '0;
            instrValid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (flush) begin
                        instrValid <= 1'b0;
                        if (target_aligned) begin
                            pc    <= nextPc;
                            state <= S_FETCH;
                        end else begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end
                    end else if (I_MEM_READY) begin
                        instr      <= I_MEM_DI;
                        instrValid <= 1'b1;
                        state      <= S_VALID;
                    end
                end

                S_VALID: begin
                    if (flush || advance) begin
                        instrValid <= 1'b0;
                        if (target_aligned) begin
                            pc    <= nextPc;
                            state <= S_FETCH;
                        end else begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end
                    end
                end

                S_FAULT: begin
                    instrValid <= 1'b0;
                    fault      <= 1'b1;
                end

                default: begin
                    // Unreachable encoding; treat it like a fault so the
                    // stage never issues requests from an unknown state.
                    instrValid <= 1'b0;
                    fault      <= 1'b1;
                    state      <= S_FAULT;
                end
            endcase
        end
    end

endmodule : fetch_stage
